// File: rtl/dtw_host_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dtw_host_bridge_pkg
//  Brief    : Shared encodings and defaults for the DTW host bridge.
//  Revision : 1.0
// ============================================================================
package dtw_host_bridge_pkg;

    localparam int WORD_LEN_DEF   = 16;
    localparam int AXIS_WIDTH_DEF = 32;
    localparam int SQG_LEN_DEF    = 250;
    localparam int SETTLE_CYC_DEF = 3;
    localparam int RESULT_WORDS   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FEED    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_SETTLE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dtw_host_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : dtw_host_bridge_if
//  Brief    : Control, AXI-Stream and FIFO signals around the DTW host bridge.
//  Revision : 1.0
// ============================================================================
interface dtw_host_bridge_if
    import dtw_host_bridge_pkg::*;
#(
    parameter int AXIS_WIDTH = AXIS_WIDTH_DEF
);
    logic                  start;
    logic [31:0]           reference_len;
    logic                  busy;
    logic                  rs;
    logic                  len_err;

    logic [AXIS_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;

    logic                  src_fifo_wren;
    logic                  src_fifo_full;
    logic [AXIS_WIDTH-1:0] src_fifo_data;

    logic                  sink_fifo_rden;
    logic                  sink_fifo_empty;
    logic [AXIS_WIDTH-1:0] sink_fifo_data;

    logic [AXIS_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        input  start, reference_len,
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  src_fifo_full, sink_fifo_empty, sink_fifo_data,
        input  m_axis_tready,
        output busy, rs, len_err, s_axis_tready,
        output src_fifo_wren, src_fifo_data, sink_fifo_rden,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output start, reference_len,
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output src_fifo_full, sink_fifo_empty, sink_fifo_data,
        output m_axis_tready,
        input  busy, rs, len_err, s_axis_tready,
        input  src_fifo_wren, src_fifo_data, sink_fifo_rden,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

endinterface
`default_nettype wire

// File: rtl/dtw_result_reader.sv
`default_nettype none
// ============================================================================
//  Module   : dtw_result_reader
//  Brief    : Reads the two result words from the sink FIFO onto AXI-Stream.
//  Revision : 1.0
// ============================================================================
module dtw_result_reader
    import dtw_host_bridge_pkg::*;
#(
    parameter int AXIS_WIDTH = AXIS_WIDTH_DEF,
    parameter int WORD_LEN   = WORD_LEN_DEF
)(
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  en,
    input  wire logic                  sink_empty,
    input  wire logic [AXIS_WIDTH-1:0] sink_data,
    output logic                       sink_rden,
    output logic [AXIS_WIDTH-1:0]      m_tdata,
    output logic                       m_tvalid,
    input  wire logic                  m_tready,
    output logic                       m_tlast,
    output logic                       done
);

    logic                  rd_pend_q, rd_pend_d;
    logic [1:0]            rd_cnt_q,  rd_cnt_d;
    logic                  tvalid_q,  tvalid_d;
    logic                  tlast_q,   tlast_d;
    logic [AXIS_WIDTH-1:0] tdata_q,   tdata_d;

    always_comb begin
        // One read in flight at a time, and only into an empty output register
        sink_rden = en && !sink_empty && !rd_pend_q && !tvalid_q &&
                    (rd_cnt_q < 2'(RESULT_WORDS));
        rd_pend_d = sink_rden;
        rd_cnt_d  = rd_cnt_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tdata_d   = tdata_q;

        if (!en) begin
            rd_cnt_d = 2'd0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end else begin
            if (sink_rden) begin
                rd_cnt_d = rd_cnt_q + 2'd1;
            end
            if (rd_pend_q) begin
                // Upper score bits pass through as the core supplied them
                tdata_d  = {sink_data[AXIS_WIDTH-1:WORD_LEN], sink_data[WORD_LEN-1:0]};
                tvalid_d = 1'b1;
                tlast_d  = (rd_cnt_q == 2'(RESULT_WORDS));
            end else if (tvalid_q && m_tready) begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            rd_cnt_q  <= 2'd0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_cnt_q  <= rd_cnt_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;
    assign done     = tvalid_q && m_tready && tlast_q;

endmodule
`default_nettype wire

// File: rtl/dtw_host_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : dtw_host_bridge
//  Brief    : Feeds one DTW job into the source FIFO and returns its results.
//  Revision : 1.0
// ============================================================================
module dtw_host_bridge
    import dtw_host_bridge_pkg::*;
#(
    parameter int WORD_LEN   = WORD_LEN_DEF,
    parameter int AXIS_WIDTH = AXIS_WIDTH_DEF,
    parameter int SQG_LEN    = SQG_LEN_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
)(
    input  wire logic       clk,
    input  wire logic       rst_n,
    dtw_host_bridge_if.master bus
);

    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_e              state_q, state_d;
    logic [32:0]         total_q, total_d;
    logic [32:0]         feed_cnt_q, feed_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                len_err_q, len_err_d;
    logic                rs_q, rs_d;
    logic                busy_q, busy_d;

    logic                feed_ready;
    logic                feed_write;
    logic [32:0]         feed_next;
    logic                rr_done;

    assign feed_ready = (state_q == ST_FEED) && !bus.src_fifo_full;
    assign feed_write = feed_ready && bus.s_axis_tvalid;
    assign feed_next  = feed_cnt_q + 33'd1;

    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        feed_cnt_d   = feed_cnt_q;
        settle_cnt_d = settle_cnt_q;
        len_err_d    = len_err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    total_d    = 33'(SQG_LEN) + {1'b0, bus.reference_len};
                    feed_cnt_d = 33'd0;
                    len_err_d  = 1'b0;
                    state_d    = ST_FEED;
                end
            end
            ST_FEED: begin
                // The word count ends the phase; TLAST only feeds the error flag
                if (feed_write) begin
                    feed_cnt_d = feed_next;
                    if (feed_next == total_q) begin
                        if (!bus.s_axis_tlast) begin
                            len_err_d = 1'b1;
                        end
                        state_d = ST_COLLECT;
                    end else if (bus.s_axis_tlast) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (rr_done) begin
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_W'(SETTLE_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rs_d   = (state_d == ST_FEED);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            total_q      <= 33'd0;
            feed_cnt_q   <= 33'd0;
            settle_cnt_q <= '0;
            len_err_q    <= 1'b0;
            rs_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            feed_cnt_q   <= feed_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            len_err_q    <= len_err_d;
            rs_q         <= rs_d;
            busy_q       <= busy_d;
        end
    end

    dtw_result_reader #(
        .AXIS_WIDTH (AXIS_WIDTH),
        .WORD_LEN   (WORD_LEN)
    ) u_result_reader (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_q == ST_COLLECT),
        .sink_empty (bus.sink_fifo_empty),
        .sink_data  (bus.sink_fifo_data),
        .sink_rden  (bus.sink_fifo_rden),
        .m_tdata    (bus.m_axis_tdata),
        .m_tvalid   (bus.m_axis_tvalid),
        .m_tready   (bus.m_axis_tready),
        .m_tlast    (bus.m_axis_tlast),
        .done       (rr_done)
    );

    assign bus.busy          = busy_q;
    assign bus.rs            = rs_q;
    assign bus.len_err       = len_err_q;
    assign bus.s_axis_tready = feed_ready;
    assign bus.src_fifo_wren = feed_write;
    assign bus.src_fifo_data = feed_write ? bus.s_axis_tdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dtw_host_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dtw_host_bridge
//  Brief    : Randomized self-checking bench for dtw_host_bridge.
//  Revision : 1.0
// ============================================================================
module tb_dtw_host_bridge;
    import dtw_host_bridge_pkg::*;

    localparam int SQG    = 250;
    localparam int SETTLE = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dtw_host_bridge_if #(.AXIS_WIDTH(32)) bus ();

    dtw_host_bridge #(
        .WORD_LEN   (16),
        .AXIS_WIDTH (32),
        .SQG_LEN    (SQG),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // environment / model state
    logic [31:0] src_words[$];
    bit          src_last[$];
    int          src_idx;
    logic [31:0] got_src[$];
    logic [32:0] got_out[$];
    logic [32:0] out0, out1;
    logic [31:0] sink_q[$];
    logic [31:0] res_pending[$];
    int          res_delay;
    bit          prev_rden;
    int          rden_cnt;
    int          full_mode;
    bit          tready_rand;
    int          stall_left;
    int          valid_pct;
    bit          start_req;
    bit          rst_req;
    logic [31:0] ref_len_drv;
    int          cyc;
    bit          start_acc;
    int          start_cyc, last_wr_cyc, last_hs_cyc;
    int          rs_cycles, full_viol, hold_viol, hs_viol;
    bit          exp_len_err;
    bit          prev_mvalid, prev_mready, prev_mlast;
    logic [31:0] prev_mdata;

    // One clock cycle: drive inputs after the falling edge, sample shortly after.
    task automatic step();
        bit hs;
        @(negedge clk);
        cyc++;
        rst_n             = !rst_req;
        bus.start         = start_req;
        bus.reference_len = ref_len_drv;
        if (prev_rden) bus.sink_fifo_data = (sink_q.size() > 0) ? sink_q.pop_front() : 32'hDEAD_BEEF;
        if (res_pending.size() > 0 && src_words.size() > 0 && src_idx == src_words.size()) begin
            res_delay++;
            if (res_delay >= 4) begin
                foreach (res_pending[i]) sink_q.push_back(res_pending[i]);
                res_pending.delete();
            end
        end
        bus.sink_fifo_empty = (sink_q.size() == 0);
        case (full_mode)
            1:       bus.src_fifo_full = (cyc % 3 == 0);
            2:       bus.src_fifo_full = ($urandom_range(0, 3) == 0);
            default: bus.src_fifo_full = 1'b0;
        endcase
        if (src_idx < src_words.size()) begin
            bus.s_axis_tvalid = ($urandom_range(0, 99) < valid_pct);
            bus.s_axis_tdata  = src_words[src_idx];
            bus.s_axis_tlast  = src_last[src_idx];
        end else begin
            bus.s_axis_tvalid = 1'b0;
            bus.s_axis_tdata  = $urandom;
            bus.s_axis_tlast  = $urandom_range(0, 1) == 1;
        end
        if (stall_left > 0)   bus.m_axis_tready = 1'b0;
        else if (tready_rand) bus.m_axis_tready = ($urandom_range(0, 1) == 1);
        else                  bus.m_axis_tready = 1'b1;
        #1;
        if (start_req && bus.busy === 1'b0 && !rst_req) begin
            start_acc = 1'b1;
            start_cyc = cyc;
        end
        if (bus.rs === 1'b1) rs_cycles++;
        if (bus.src_fifo_full && bus.s_axis_tready) full_viol++;
        hs = bus.s_axis_tvalid && bus.s_axis_tready;
        if (bus.src_fifo_wren !== hs) hs_viol++;
        if (bus.src_fifo_wren === 1'b1) begin
            got_src.push_back(bus.src_fifo_data);
            last_wr_cyc = cyc;
        end
        if (hs && src_idx < src_words.size()) src_idx++;
        if (bus.sink_fifo_rden === 1'b1) rden_cnt++;
        prev_rden = (bus.sink_fifo_rden === 1'b1);
        if (prev_mvalid && !prev_mready &&
            (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== prev_mdata || bus.m_axis_tlast !== prev_mlast))
            hold_viol++;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            got_out.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
            last_hs_cyc = cyc;
        end
        if (bus.m_axis_tvalid && stall_left > 0) stall_left--;
        prev_mvalid = (bus.m_axis_tvalid === 1'b1) && !rst_req;
        prev_mready = bus.m_axis_tready;
        prev_mdata  = bus.m_axis_tdata;
        prev_mlast  = bus.m_axis_tlast;
    endtask

    // Build a job: bad_pos 0 = TLAST on the final word, >0 = TLAST only on that
    // 1-based word, <0 = no TLAST at all.
    task automatic prepare_job(input int ref_len, input int bad_pos,
                               input logic [31:0] pos, input logic [31:0] score, input int vpct);
        int total;
        int n_last;
        total = SQG + ref_len;
        src_words.delete();
        src_last.delete();
        n_last = 0;
        for (int i = 0; i < total; i++) begin
            bit l;
            src_words.push_back($urandom);
            if (bad_pos == 0)     l = (i == total - 1);
            else if (bad_pos > 0) l = (i == bad_pos - 1);
            else                  l = 1'b0;
            src_last.push_back(l);
            if (l) n_last++;
        end
        exp_len_err = !(n_last == 1 && src_last[total-1]);
        src_idx = 0;
        got_src.delete();
        got_out.delete();
        sink_q.delete();
        res_pending.delete();
        res_pending.push_back(pos);
        res_pending.push_back(score);
        res_delay   = 0;
        rden_cnt    = 0;
        rs_cycles   = 0;
        full_viol   = 0;
        hold_viol   = 0;
        hs_viol     = 0;
        ref_len_drv = ref_len;
        valid_pct   = vpct;
        start_acc   = 1'b0;
        start_cyc   = -1;
        last_wr_cyc = -1;
        out0        = 'x;
        out1        = 'x;
    endtask

    task automatic pulse_start();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            step();
            n++;
        end
        start_req = 1'b1;
        step();
        start_req = 1'b0;
    endtask

    task automatic finish_job(input int budget, input bit poke_collect, output bit timeout);
        int n = 0;
        bit poked = 1'b0;
        while (got_out.size() < 2 && n < budget) begin
            if (poke_collect && !poked && src_idx == src_words.size()) begin
                start_req = 1'b1;
                poked     = 1'b1;
            end
            step();
            start_req = 1'b0;
            n++;
        end
        timeout = (got_out.size() < 2);
        if (got_out.size() > 0) out0 = got_out[0];
        if (got_out.size() > 1) out1 = got_out[1];
    endtask

    function automatic bit src_match();
        if (got_src.size() != src_words.size()) return 1'b0;
        foreach (src_words[i]) if (got_src[i] !== src_words[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        n_checks++;
        if ({bus.busy, bus.rs, bus.len_err, bus.s_axis_tready, bus.src_fifo_wren,
             bus.sink_fifo_rden, bus.m_axis_tvalid, bus.m_axis_tlast} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=00000000", {bus.busy, bus.rs, bus.len_err, bus.s_axis_tready,
                     bus.src_fifo_wren, bus.sink_fifo_rden, bus.m_axis_tvalid, bus.m_axis_tlast});
        end
        n_checks++;
        if (bus.m_axis_tdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_tdata got=%h exp=0", bus.m_axis_tdata);
        end
        step();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_basic();
        bit to;
        full_mode = 0; tready_rand = 0; stall_left = 0;
        prepare_job(4, 0, 32'd37, 32'h0000_01F2, 100);
        pulse_start();
        finish_job(3000, 1'b0, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL basic_timeout got=%0d exp=2 words", got_out.size()); end
        n_checks++;
        if (!src_match()) begin n_fail++; $display("FAIL basic_src got=%0d words exp=%0d in order", got_src.size(), src_words.size()); end
        n_checks++;
        if (last_wr_cyc - start_cyc !== 254) begin n_fail++; $display("FAIL basic_feed_cycles got=%0d exp=254", last_wr_cyc - start_cyc); end
        n_checks++;
        if (rs_cycles !== last_wr_cyc - start_cyc) begin n_fail++; $display("FAIL basic_rs_cycles got=%0d exp=%0d", rs_cycles, last_wr_cyc - start_cyc); end
        n_checks++;
        if (out0 !== {1'b0, 32'd37}) begin n_fail++; $display("FAIL basic_out0 got=%h exp=%h", out0, {1'b0, 32'd37}); end
        n_checks++;
        if (out1 !== {1'b1, 32'h1F2}) begin n_fail++; $display("FAIL basic_out1 got=%h exp=%h", out1, {1'b1, 32'h1F2}); end
        n_checks++;
        if (bus.len_err !== 1'b0) begin n_fail++; $display("FAIL basic_len_err got=%b exp=0", bus.len_err); end
        n_checks++;
        if (rden_cnt !== 2 || hs_viol !== 0) begin n_fail++; $display("FAIL basic_rden got=%0d/%0d exp=2/0", rden_cnt, hs_viol); end
    endtask

    task automatic test_full_stall();
        bit to;
        full_mode = 1; tready_rand = 0; stall_left = 0;
        prepare_job(4, 0, 32'd37, 32'h0000_01F2, 100);
        pulse_start();
        finish_job(3000, 1'b0, to);
        full_mode = 0;
        n_checks++;
        if (to || !src_match()) begin n_fail++; $display("FAIL full_src got=%0d words to=%0b exp=%0d in order", got_src.size(), to, src_words.size()); end
        n_checks++;
        if (full_viol !== 0 || hs_viol !== 0) begin n_fail++; $display("FAIL full_tready got=%0d/%0d exp=0/0", full_viol, hs_viol); end
        n_checks++;
        if (out0 !== {1'b0, 32'd37} || out1 !== {1'b1, 32'h1F2}) begin n_fail++; $display("FAIL full_out got=%h,%h exp=%h,%h", out0, out1, {1'b0, 32'd37}, {1'b1, 32'h1F2}); end
    endtask

    task automatic test_len_err();
        bit to;
        full_mode = 0; tready_rand = 0; stall_left = 0;
        prepare_job(4, 100, 32'd37, 32'h0000_01F2, 100);
        pulse_start();
        finish_job(3000, 1'b0, to);
        n_checks++;
        if (to || !src_match()) begin n_fail++; $display("FAIL lerr_feed got=%0d words to=%0b exp=%0d", got_src.size(), to, src_words.size()); end
        n_checks++;
        if (bus.len_err !== exp_len_err) begin n_fail++; $display("FAIL lerr_early got=%b exp=%b", bus.len_err, exp_len_err); end
        n_checks++;
        if (out0 !== {1'b0, 32'd37} || out1 !== {1'b1, 32'h1F2}) begin n_fail++; $display("FAIL lerr_out got=%h,%h exp=%h,%h", out0, out1, {1'b0, 32'd37}, {1'b1, 32'h1F2}); end

        prepare_job(0, 0, 32'd5, 32'd6, 100);
        pulse_start();
        step();
        n_checks++;
        if (bus.len_err !== 1'b0) begin n_fail++; $display("FAIL lerr_clear got=%b exp=0", bus.len_err); end
        finish_job(3000, 1'b0, to);
        n_checks++;
        if (to || bus.len_err !== exp_len_err) begin n_fail++; $display("FAIL lerr_clean got=%b to=%0b exp=%b", bus.len_err, to, exp_len_err); end

        prepare_job(2, -1, 32'd7, 32'd8, 100);
        pulse_start();
        finish_job(3000, 1'b0, to);
        n_checks++;
        if (to || bus.len_err !== exp_len_err) begin n_fail++; $display("FAIL lerr_missing got=%b to=%0b exp=%b", bus.len_err, to, exp_len_err); end
    endtask

    task automatic test_tready_stall();
        bit to;
        full_mode = 0; tready_rand = 0; stall_left = 5;
        prepare_job(4, 0, 32'd37, 32'h0000_01F2, 100);
        pulse_start();
        finish_job(3000, 1'b0, to);
        n_checks++;
        if (to || hold_viol !== 0) begin n_fail++; $display("FAIL stall_hold got=%0d to=%0b exp=0", hold_viol, to); end
        n_checks++;
        if (rden_cnt !== 2) begin n_fail++; $display("FAIL stall_rden got=%0d exp=2", rden_cnt); end
        n_checks++;
        if (out0 !== {1'b0, 32'd37} || out1 !== {1'b1, 32'h1F2}) begin n_fail++; $display("FAIL stall_out got=%h,%h exp=%h,%h", out0, out1, {1'b0, 32'd37}, {1'b1, 32'h1F2}); end
    endtask

    task automatic test_reset_midjob();
        bit to;
        int n = 0;
        full_mode = 0; tready_rand = 0; stall_left = 0;
        prepare_job(4, 0, 32'd11, 32'd22, 100);
        pulse_start();
        while (src_idx < 120 && n < 1000) begin step(); n++; end
        res_pending.delete();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        sink_q.delete();
        prev_rden = 1'b0;
        step();
        n_checks++;
        if ({bus.busy, bus.rs, bus.len_err, bus.s_axis_tready, bus.src_fifo_wren,
             bus.sink_fifo_rden, bus.m_axis_tvalid, bus.m_axis_tlast} !== 8'h00 || bus.m_axis_tdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs got=%b/%h exp=00000000/0", {bus.busy, bus.rs, bus.len_err, bus.s_axis_tready,
                     bus.src_fifo_wren, bus.sink_fifo_rden, bus.m_axis_tvalid, bus.m_axis_tlast}, bus.m_axis_tdata);
        end
        prepare_job(4, 0, 32'd37, 32'hABCD_01F2, 100);
        pulse_start();
        finish_job(3000, 1'b0, to);
        n_checks++;
        if (to || !src_match() || bus.len_err !== 1'b0) begin n_fail++; $display("FAIL midrst_rerun got=%0d words len_err=%b exp=%0d/0", got_src.size(), bus.len_err, src_words.size()); end
        n_checks++;
        if (out0 !== {1'b0, 32'd37} || out1 !== {1'b1, 32'hABCD_01F2}) begin n_fail++; $display("FAIL midrst_out got=%h,%h exp=%h,%h", out0, out1, {1'b0, 32'd37}, {1'b1, 32'hABCD_01F2}); end
    endtask

    task automatic test_settle();
        bit to;
        int h;
        int n = 0;
        full_mode = 0; tready_rand = 0; stall_left = 0;
        prepare_job(3, 0, 32'd1, 32'd2, 100);
        pulse_start();
        finish_job(3000, 1'b1, to);
        n_checks++;
        if (to || out0 !== {1'b0, 32'd1} || out1 !== {1'b1, 32'd2} || rs_cycles !== last_wr_cyc - start_cyc) begin
            n_fail++; $display("FAIL settle_collect_start got=%h,%h rs=%0d exp=%h,%h rs=%0d", out0, out1, rs_cycles, {1'b0, 32'd1}, {1'b1, 32'd2}, last_wr_cyc - start_cyc);
        end
        h = last_hs_cyc;
        prepare_job(1, 0, 32'd3, 32'd4, 100);
        start_req = 1'b1;
        while (!start_acc && n < 20) begin step(); n++; end
        start_req = 1'b0;
        n_checks++;
        if (start_cyc - h !== SETTLE + 1) begin n_fail++; $display("FAIL settle_accept got=%0d exp=%0d", start_cyc - h, SETTLE + 1); end
        finish_job(3000, 1'b0, to);
        n_checks++;
        if (to || !src_match() || out0 !== {1'b0, 32'd3} || out1 !== {1'b1, 32'd4}) begin n_fail++; $display("FAIL settle_next_job got=%h,%h exp=%h,%h", out0, out1, {1'b0, 32'd3}, {1'b1, 32'd4}); end
    endtask

    task automatic test_random();
        bit to;
        for (int it = 0; it < 4; it++) begin
            int rl;
            logic [31:0] p, s;
            rl = (it == 0) ? 0 : $urandom_range(1, 12);
            p  = $urandom;
            s  = $urandom;
            full_mode = 2; tready_rand = 1; stall_left = 0;
            prepare_job(rl, (it == 2) ? $urandom_range(1, SQG + rl - 1) : 0, p, s, $urandom_range(50, 100));
            pulse_start();
            finish_job(4000, 1'b0, to);
            n_checks++;
            if (to || !src_match()) begin n_fail++; $display("FAIL rand_src it=%0d got=%0d words exp=%0d", it, got_src.size(), src_words.size()); end
            n_checks++;
            if (out0 !== {1'b0, p} || out1 !== {1'b1, s}) begin n_fail++; $display("FAIL rand_out it=%0d got=%h,%h exp=%h,%h", it, out0, out1, {1'b0, p}, {1'b1, s}); end
            n_checks++;
            if (bus.len_err !== exp_len_err) begin n_fail++; $display("FAIL rand_len_err it=%0d got=%b exp=%b", it, bus.len_err, exp_len_err); end
            n_checks++;
            if (rden_cnt !== 2 || full_viol + hold_viol + hs_viol !== 0 || rs_cycles !== last_wr_cyc - start_cyc) begin
                n_fail++; $display("FAIL rand_proto it=%0d got rden=%0d viol=%0d rs=%0d exp rden=2 viol=0 rs=%0d", it, rden_cnt, full_viol + hold_viol + hs_viol, rs_cycles, last_wr_cyc - start_cyc);
            end
            for (int k = 0; k < SETTLE + 2; k++) step();
            n_checks++;
            if (bus.busy !== 1'b0 || bus.rs !== 1'b0) begin n_fail++; $display("FAIL rand_idle it=%0d got=%b%b exp=00", it, bus.busy, bus.rs); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.reference_len = '0;
        bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
        bus.src_fifo_full = 1'b0; bus.sink_fifo_empty = 1'b1; bus.sink_fifo_data = '0;
        bus.m_axis_tready = 1'b0;
        cyc = 0; start_req = 0; rst_req = 0; prev_rden = 0; full_mode = 0;
        tready_rand = 0; stall_left = 0; valid_pct = 100; ref_len_drv = '0;
        prev_mvalid = 0; prev_mready = 0; prev_mlast = 0; prev_mdata = '0;
        src_idx = 0; res_delay = 0; rden_cnt = 0; rs_cycles = 0;
        full_viol = 0; hold_viol = 0; hs_viol = 0; last_hs_cyc = 0;
        start_acc = 0; start_cyc = -1; last_wr_cyc = -1; exp_len_err = 0;
        test_reset();
        test_basic();
        test_full_stall();
        test_len_err();
        test_tready_stall();
        test_reset_midjob();
        test_settle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
